uart_rx_fifo: RTL

Parametrised UART receiver, the next generation of the existing 8-bit serial receive path. It adds configurable data width, bit period and optional parity, plus a receive FIFO in place of the single-entry data buffer. It takes the raw asynchronous `serial_in` line and presents received words through a show-ahead FIFO. Status flags cover framing, parity and overrun errors.

---
 rtl/uart_rx_fifo.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : parametrised UART receiver feeding a show-ahead receive FIFO
// Rev 1.0 : initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          serial_in,
  input  logic                          data_read,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          framing_error,
  output logic                          parity_error,
  output logic                          overrun_error
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CNTW-1:0] BIT_LAST   = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HALF_LAST  = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]   DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic            PAR_ODD    = (PARITY_ODD != 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                 sync_q, rx_s_q, rx_prev_q;
  logic [2:0]           state_q, state_d;
  logic [CNTW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_fail_q, par_fail_d;
  logic                 framing_error_q, framing_error_d;
  logic                 parity_error_q, parity_error_d;
  logic                 wr_pend_q, wr_pend_d;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];

  logic fall, half_done, bit_done, par_bad;
  logic pop, full, push, drop;

  assign fall      = rx_prev_q & ~rx_s_q;
  assign half_done = (clk_cnt_q == HALF_LAST);
  assign bit_done  = (clk_cnt_q == BIT_LAST);
  // Parity bit is folded into the XOR of the data; the result must equal the odd/even selector.
  assign par_bad   = (PARITY_EN != 0) && (((^shift_q) ^ rx_s_q) != PAR_ODD);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (fall) state_d = ST_START;
      ST_START:  if (half_done) state_d = rx_s_q ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_done && (bit_cnt_q == DATA_LAST))
                   state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) state_d = ST_STOP;
      ST_STOP:   if (bit_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clk_cnt_d       = clk_cnt_q + CNTW'(1);
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    par_fail_d      = par_fail_q;
    framing_error_d = framing_error_q;
    parity_error_d  = parity_error_q;
    wr_pend_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (fall) begin
          bit_cnt_d       = '0;
          par_fail_d      = 1'b0;
          framing_error_d = 1'b0;
          parity_error_d  = 1'b0;
        end
      end
      ST_START: if (half_done) clk_cnt_d = '0;
      ST_DATA: if (bit_done) begin
        clk_cnt_d = '0;
        shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
      ST_PARITY: if (bit_done) begin
        clk_cnt_d  = '0;
        par_fail_d = par_bad;
      end
      // Only a clean frame raises the write request serviced on the following edge.
      ST_STOP: if (bit_done) begin
        clk_cnt_d       = '0;
        framing_error_d = ~rx_s_q;
        parity_error_d  = par_fail_q;
        wr_pend_d       = rx_s_q & ~par_fail_q;
      end
      default: clk_cnt_d = '0;
    endcase
  end

  assign pop  = data_read && (count_q != '0);
  assign full = (count_q == FULL_COUNT);
  assign push = wr_pend_q && (!full || pop);
  assign drop = wr_pend_q && full && !pop;

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (pop) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q          <= 1'b1;
      rx_s_q          <= 1'b1;
      rx_prev_q       <= 1'b1;
      clk_cnt_q       <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      par_fail_q      <= 1'b0;
      framing_error_q <= 1'b0;
      parity_error_q  <= 1'b0;
      wr_pend_q       <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      overrun_q       <= 1'b0;
    end else begin
      sync_q          <= serial_in;
      rx_s_q          <= sync_q;
      rx_prev_q       <= rx_s_q;
      clk_cnt_q       <= clk_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_fail_q      <= par_fail_d;
      framing_error_q <= framing_error_d;
      parity_error_q  <= parity_error_d;
      wr_pend_q       <= wr_pend_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      overrun_q       <= overrun_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign data_ready    = (count_q != '0);
  assign rx_data       = data_ready ? fifo_mem_q[rd_ptr_q] : '0;
  assign fifo_count    = count_q;
  assign framing_error = framing_error_q;
  assign parity_error  = parity_error_q;
  assign overrun_error = overrun_q;

endmodule
`default_nettype wire
